// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared definitions for the ALU execute-stage controller.
//   - Datapath, register-count and select widths
//   - Register index width derived from the register count
//   - FSM state encoding (IDLE / OPER / CAPT)
//   - Reset value constants for datapath and select registers
package alu_exec_pkg;

    localparam int DATA_W = 8;
    localparam int NREG   = 4;
    localparam int SEL_W  = 4;
    localparam int IDX_W  = $clog2(NREG);

    localparam logic [DATA_W-1:0] RST_DATA = '0;
    localparam logic [SEL_W-1:0]  RST_SEL  = '0;
    localparam logic [IDX_W-1:0]  RST_IDX  = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPER = 2'd1,
        ST_CAPT = 2'd2
    } exec_state_t;

endpackage

// File: rtl/exec_regfile.sv
// exec_regfile: NREG x DATA_W general register file.
//   clk, rst        : clock, synchronous active-high reset (all entries -> 0)
//   ra_addr/ra_data : asynchronous read port A
//   rb_addr/rb_data : asynchronous read port B
//   we/waddr/wdata  : synchronous write port
//   dbg_addr/dbg_data : extra asynchronous read port, only when
//                       ALU_EXEC_DBG_EN is defined
module exec_regfile
    import alu_exec_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int NREG_P   = NREG
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NREG_P)-1:0]   ra_addr,
    output logic [DATA_W_P-1:0]         ra_data,
    input  logic [$clog2(NREG_P)-1:0]   rb_addr,
    output logic [DATA_W_P-1:0]         rb_data,
`ifdef ALU_EXEC_DBG_EN
    input  logic [$clog2(NREG_P)-1:0]   dbg_addr,
    output logic [DATA_W_P-1:0]         dbg_data,
`endif
    input  logic                        we,
    input  logic [$clog2(NREG_P)-1:0]   waddr,
    input  logic [DATA_W_P-1:0]         wdata
);

    logic [DATA_W_P-1:0] mem_reg [NREG_P];

    // Reset has priority so a writeback coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG_P; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign ra_data = mem_reg[ra_addr];
    assign rb_data = mem_reg[rb_addr];

`ifdef ALU_EXEC_DBG_EN
    assign dbg_data = mem_reg[dbg_addr];
`endif

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage controller around a combinational 8-bit ALU.
//   clk, rst              : clock, synchronous active-high reset
//   instr_valid/ready     : decoder handshake; ready only in IDLE
//   instr_op/rd/rs/imm_en/imm : decoded instruction fields
//   alu_a/alu_b/alu_sel   : registered ALU drive, held from accept through CAPT
//   alu_out/alu_cout      : ALU result, captured when leaving CAPT
//   wb_valid/wb_data      : one-cycle writeback pulse and value
//   flag_z/flag_c         : zero/carry flags, updated only on writeback
//   busy                  : instruction in flight
// Optional: define ALU_EXEC_DBG_EN to add dbg_addr/dbg_data, a
// combinational register file read port.
module alu_exec_ctrl
    import alu_exec_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int NREG_P   = NREG,
    parameter int SEL_W_P  = SEL_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [SEL_W_P-1:0]          instr_op,
    input  logic [$clog2(NREG_P)-1:0]   instr_rd,
    input  logic [$clog2(NREG_P)-1:0]   instr_rs,
    input  logic                        instr_imm_en,
    input  logic [DATA_W_P-1:0]         instr_imm,
    output logic [DATA_W_P-1:0]         alu_a,
    output logic [DATA_W_P-1:0]         alu_b,
    output logic [SEL_W_P-1:0]          alu_sel,
    input  logic [DATA_W_P-1:0]         alu_out,
    input  logic                        alu_cout,
    output logic                        wb_valid,
    output logic [DATA_W_P-1:0]         wb_data,
    output logic                        flag_z,
    output logic                        flag_c,
`ifdef ALU_EXEC_DBG_EN
    input  logic [$clog2(NREG_P)-1:0]   dbg_addr,
    output logic [DATA_W_P-1:0]         dbg_data,
`endif
    output logic                        busy
);

    localparam int IW = $clog2(NREG_P);

    exec_state_t          state_reg;
    logic                 ready_reg;
    logic                 busy_reg;
    logic [DATA_W_P-1:0]  alu_a_reg;
    logic [DATA_W_P-1:0]  alu_b_reg;
    logic [SEL_W_P-1:0]   alu_sel_reg;
    logic [IW-1:0]        rd_reg;
    logic                 wb_valid_reg;
    logic [DATA_W_P-1:0]  wb_data_reg;
    logic                 flag_z_reg;
    logic                 flag_c_reg;

    logic [DATA_W_P-1:0]  rd_data;
    logic [DATA_W_P-1:0]  rs_data;
    logic                 rf_we;

    // The register file write happens on the same edge that leaves CAPT,
    // so it lands together with wb_data and the flags.
    assign rf_we = (state_reg == ST_CAPT);

    exec_regfile #(
        .DATA_W_P (DATA_W_P),
        .NREG_P   (NREG_P)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (instr_rd),
        .ra_data  (rd_data),
        .rb_addr  (instr_rs),
        .rb_data  (rs_data),
`ifdef ALU_EXEC_DBG_EN
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
`endif
        .we       (rf_we),
        .waddr    (rd_reg),
        .wdata    (alu_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            alu_a_reg    <= DATA_W_P'(RST_DATA);
            alu_b_reg    <= DATA_W_P'(RST_DATA);
            alu_sel_reg  <= SEL_W_P'(RST_SEL);
            rd_reg       <= IW'(RST_IDX);
            wb_valid_reg <= 1'b0;
            wb_data_reg  <= DATA_W_P'(RST_DATA);
            flag_z_reg   <= 1'b0;
            flag_c_reg   <= 1'b0;
        end else begin
            wb_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (instr_valid && ready_reg) begin
                        // Both operands are read before any write of this
                        // instruction, so rd==rs sees the old value twice.
                        alu_a_reg   <= rd_data;
                        alu_b_reg   <= instr_imm_en ? instr_imm : rs_data;
                        alu_sel_reg <= instr_op;
                        rd_reg      <= instr_rd;
                        state_reg   <= ST_OPER;
                        ready_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_OPER: begin
                    // ALU settles on the held operands during this cycle.
                    state_reg <= ST_CAPT;
                end
                ST_CAPT: begin
                    wb_data_reg  <= alu_out;
                    flag_z_reg   <= (alu_out == '0);
                    flag_c_reg   <= alu_cout;
                    wb_valid_reg <= 1'b1;
                    state_reg    <= ST_IDLE;
                    ready_reg    <= 1'b1;
                    busy_reg     <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready = ready_reg;
    assign busy        = busy_reg;
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_sel     = alu_sel_reg;
    assign wb_valid    = wb_valid_reg;
    assign wb_data     = wb_data_reg;
    assign flag_z      = flag_z_reg;
    assign flag_c      = flag_c_reg;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed, table-driven bench for alu_exec_ctrl.
// Contains a small ALU model (sel 0 = A+B with carry, sel 1 = A&B,
// others A^B) closing the loop between alu_a/alu_b/alu_sel and
// alu_out/alu_cout.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs;
    logic       instr_imm_en;
    logic [7:0] instr_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_cout;
    logic       wb_valid;
    logic [7:0] wb_data;
    logic       flag_z;
    logic       flag_c;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs     (instr_rs),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_out      (alu_out),
        .alu_cout     (alu_cout),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .busy         (busy)
    );

    always_comb begin
        alu_out  = 8'h00;
        alu_cout = 1'b0;
        case (alu_sel)
            4'd0:    {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1:    alu_out = alu_a & alu_b;
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       imm_en;
        logic [7:0] imm;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] exp_wb;
        logic       exp_z;
        logic       exp_c;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present an instruction and wait for it to be accepted; returns #1
    // after the accepting edge with instr_valid dropped.
    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic imm_en, input logic [7:0] imm);
        int n;
        @(negedge clk);
        instr_op     = op;
        instr_rd     = rd;
        instr_rs     = rs;
        instr_imm_en = imm_en;
        instr_imm    = imm;
        instr_valid  = 1'b1;
        n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL accept_timeout: ready never rose within %0d cycles", n);
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input logic pz, input logic pc);
        vec_t v;
        v = vecs[idx];
        send(v.op, v.rd, v.rs, v.imm_en, v.imm);
        @(negedge clk);
        chk($sformatf("v%0d alu_a", idx), 32'(alu_a), 32'(v.exp_a));
        chk($sformatf("v%0d alu_b", idx), 32'(alu_b), 32'(v.exp_b));
        chk($sformatf("v%0d alu_sel", idx), 32'(alu_sel), 32'(v.op));
        chk($sformatf("v%0d oper_busy", idx), 32'({busy, instr_ready, wb_valid}), 32'(3'b100));
        chk($sformatf("v%0d flags_hold", idx), 32'({flag_z, flag_c}), 32'({pz, pc}));
        @(negedge clk);
        chk($sformatf("v%0d capt_state", idx), 32'({busy, instr_ready, wb_valid}), 32'(3'b100));
        @(negedge clk);
        chk($sformatf("v%0d wb_pulse", idx), 32'({busy, instr_ready, wb_valid}), 32'(3'b011));
        chk($sformatf("v%0d wb_data", idx), 32'(wb_data), 32'(v.exp_wb));
        chk($sformatf("v%0d flags", idx), 32'({flag_z, flag_c}), 32'({v.exp_z, v.exp_c}));
        @(negedge clk);
        chk($sformatf("v%0d wb_one_cycle", idx), 32'(wb_valid), 32'(0));
        $display("vec %0d: op=%0d rd=%0d rs=%0d imm_en=%0d imm=%02h -> wb=%02h z=%0d c=%0d",
                 idx, v.op, v.rd, v.rs, v.imm_en, v.imm, wb_data, flag_z, flag_c);
    endtask

    initial begin : main
        logic pz;
        logic pc;
        int   acc;
        int   wb_cnt;
        int   wb_idx [4];
        logic [7:0] wb_val [4];

        //        op    rd    rs    ie    imm    a      b      wb     z     c
        vecs[0] = '{4'd0, 2'd1, 2'd0, 1'b1, 8'h0A, 8'h00, 8'h0A, 8'h0A, 1'b0, 1'b0};
        vecs[1] = '{4'd0, 2'd2, 2'd0, 1'b1, 8'h12, 8'h00, 8'h12, 8'h12, 1'b0, 1'b0};
        vecs[2] = '{4'd0, 2'd1, 2'd2, 1'b0, 8'h00, 8'h0A, 8'h12, 8'h1C, 1'b0, 1'b0};
        vecs[3] = '{4'd0, 2'd3, 2'd0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{4'd0, 2'd3, 2'd0, 1'b1, 8'h01, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{4'd0, 2'd1, 2'd1, 1'b0, 8'h00, 8'h1C, 8'h1C, 8'h38, 1'b0, 1'b0};
        vecs[6] = '{4'd0, 2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{4'd1, 2'd1, 2'd0, 1'b1, 8'h0F, 8'h38, 8'h0F, 8'h08, 1'b0, 1'b0};

        rst = 1'b1;
        instr_valid = 1'b0;
        instr_op = 4'd0;
        instr_rd = 2'd0;
        instr_rs = 2'd0;
        instr_imm_en = 1'b0;
        instr_imm = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", 32'({instr_ready, busy, wb_valid}), 32'(3'b100));
        chk("reset_flags", 32'({flag_z, flag_c}), 32'(0));
        chk("reset_alu", 32'({alu_a, alu_b, alu_sel}), 32'(0));
        chk("reset_wb_data", 32'(wb_data), 32'(0));
        $display("reset: ready=%0d busy=%0d z=%0d c=%0d", instr_ready, busy, flag_z, flag_c);

        pz = 1'b0;
        pc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_vec(i, pz, pc);
            pz = vecs[i].exp_z;
            pc = vecs[i].exp_c;
        end

        // Held valid: a prior instruction r0 <- 0+0x05 is accepted at E0,
        // then r2 += 1 is held for edges E1..E10 -> accepts at E3, E6, E9.
        // r2 is 0x12, so writebacks are 0x13, 0x14, 0x15.
        send(4'd0, 2'd0, 2'd0, 1'b1, 8'h05);
        instr_op = 4'd0;
        instr_rd = 2'd2;
        instr_rs = 2'd0;
        instr_imm_en = 1'b1;
        instr_imm = 8'h01;
        instr_valid = 1'b1;
        acc = 0;
        wb_cnt = 0;
        for (int m = 0; m <= 12; m++) begin
            @(negedge clk);
            if (m == 10) instr_valid = 1'b0;
            if (m <= 9 && instr_ready) acc++;
            if (wb_valid) begin
                if (wb_cnt < 4) begin
                    wb_idx[wb_cnt] = m;
                    wb_val[wb_cnt] = wb_data;
                end
                wb_cnt++;
            end
        end
        chk("held_accepts", 32'(acc), 32'(3));
        chk("held_wb_count", 32'(wb_cnt), 32'(4));
        if (wb_cnt == 4) begin
            chk("held_wb0_at", 32'(wb_idx[0]), 32'(2));
            chk("held_wb0_data", 32'(wb_val[0]), 32'(8'h05));
            chk("held_wb1_at", 32'(wb_idx[1]), 32'(5));
            chk("held_wb1_data", 32'(wb_val[1]), 32'(8'h13));
            chk("held_wb2_at", 32'(wb_idx[2]), 32'(8));
            chk("held_wb2_data", 32'(wb_val[2]), 32'(8'h14));
            chk("held_wb3_at", 32'(wb_idx[3]), 32'(11));
            chk("held_wb3_data", 32'(wb_val[3]), 32'(8'h15));
        end
        $display("held valid: accepts=%0d wb_pulses=%0d", acc, wb_cnt);

        // Reset during OPER: the in-flight r1 <- r1+0x77 is discarded.
        send(4'd0, 2'd1, 2'd0, 1'b1, 8'h77);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        instr_op = 4'd0;
        instr_rd = 2'd1;
        instr_rs = 2'd0;
        instr_imm_en = 1'b1;
        instr_imm = 8'h21;
        instr_valid = 1'b1;
        @(negedge clk);
        chk("rst_oper_ctrl", 32'({instr_ready, busy, wb_valid}), 32'(3'b100));
        chk("rst_oper_flags", 32'({flag_z, flag_c}), 32'(0));
        chk("rst_oper_alu", 32'({alu_a, alu_b, alu_sel}), 32'(0));
        chk("rst_oper_wb_data", 32'(wb_data), 32'(0));
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_accept", 32'({busy, instr_ready}), 32'(2'b10));
        chk("post_rst_alu_a", 32'(alu_a), 32'(8'h00));
        chk("post_rst_alu_b", 32'(alu_b), 32'(8'h21));
        chk("post_rst_no_stale_wb", 32'(wb_valid), 32'(0));
        @(negedge clk);
        chk("post_rst_capt_no_wb", 32'(wb_valid), 32'(0));
        @(negedge clk);
        chk("post_rst_wb", 32'({wb_valid, wb_data}), 32'({1'b1, 8'h21}));
        chk("post_rst_flags", 32'({flag_z, flag_c}), 32'(0));
        $display("reset in OPER: new wb=%02h", wb_data);

        // Registers cleared by reset: r2 + r3 must read 0 + 0.
        send(4'd0, 2'd2, 2'd3, 1'b0, 8'h00);
        @(negedge clk);
        chk("cleared_r2", 32'(alu_a), 32'(0));
        chk("cleared_r3", 32'(alu_b), 32'(0));
        repeat (2) @(negedge clk);
        chk("cleared_wb", 32'({wb_valid, wb_data, flag_z, flag_c}), 32'({1'b1, 8'h00, 1'b1, 1'b0}));
        $display("cleared regs: wb=%02h z=%0d", wb_data, flag_z);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
